// File: rtl/dram_read_master_if.sv
// AXI4 read-address and read-data channels between the DRAM read master and the interconnect.
interface dram_read_master_if #(
   parameter int unsigned DRAM_ADDR_WIDTH = 39,
   parameter int unsigned DRAM_DATA_WIDTH = 128
);
   logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr;
   logic [7:0]                 m_axi_arlen;
   logic [2:0]                 m_axi_arsize;
   logic [1:0]                 m_axi_arburst;
   logic                       m_axi_arvalid;
   logic                       m_axi_arready;
   logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata;
   logic [1:0]                 m_axi_rresp;
   logic                       m_axi_rlast;
   logic                       m_axi_rvalid;
   logic                       m_axi_rready;

   modport master (
      output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
      input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
   );

   modport slave (
      input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid, m_axi_rready,
      output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid
   );
endinterface

// File: rtl/dram_read_master.sv
// Turns a single DRAM read request into one or two AXI INCR bursts that never cross a 4 KB
// boundary, forwarding each returned beat one cycle after its R handshake.
module dram_read_master #(
   parameter int unsigned DRAM_ADDR_WIDTH = 39,
   parameter int unsigned DRAM_DATA_WIDTH = 128
) (
   input  logic                       m_axi_aclk,
   input  logic                       m_axi_reset,
   input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
   input  logic [7:0]                 dram_read_len,
   input  logic                       dram_read_en,
   output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
   output logic                       dram_read_data_valid,
   output logic                       dram_read_busy,
   input  logic                       dram_buffer_full,
   output logic                       read_error,
   dram_read_master_if.master         axi
);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e                     state_q, state_d;
   logic [DRAM_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]                 arlen_q, arlen_d;
   logic                       arvalid_q, arvalid_d;
   logic [8:0]                 remaining_q, remaining_d;
   logic [8:0]                 burst_left_q, burst_left_d;
   logic [DRAM_DATA_WIDTH-1:0] data_q, data_d;
   logic                       valid_q, valid_d;
   logic                       busy_q, busy_d;
   logic                       error_q, error_d;

   logic [DRAM_ADDR_WIDTH-1:0] start_addr, next_addr;
   logic [8:0]                 start_rem, start_beats, cur_beats, next_rem, next_beats;
   logic                       rready, r_hs;

   // Beats that fit before the next 4 KB boundary, capped by what is still owed.
   function automatic logic [8:0] burst_beats(input logic [7:0] line, input logic [8:0] rem);
      logic [8:0] room;
      room = 9'd256 - {1'b0, line};
      return (rem < room) ? rem : room;
   endfunction

   assign start_addr  = dram_read_addr & ~DRAM_ADDR_WIDTH'(15);
   assign start_rem   = {1'b0, dram_read_len} + 9'd1;
   assign start_beats = burst_beats(start_addr[11:4], start_rem);
   assign cur_beats   = {1'b0, arlen_q} + 9'd1;
   assign next_addr   = araddr_q + DRAM_ADDR_WIDTH'({cur_beats, 4'b0000});
   assign next_rem    = remaining_q - 9'd1;
   assign next_beats  = burst_beats(next_addr[11:4], next_rem);

   assign rready = (state_q == StData) && !dram_buffer_full;
   assign r_hs   = axi.m_axi_rvalid && rready;

   always_comb begin
      state_d      = state_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      arvalid_d    = arvalid_q;
      remaining_d  = remaining_q;
      burst_left_d = burst_left_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      busy_d       = busy_q;
      error_d      = error_q;
      case (state_q)
         StIdle: begin
            if (dram_read_en) begin
               araddr_d     = start_addr;
               remaining_d  = start_rem;
               arlen_d      = 8'(start_beats - 9'd1);
               burst_left_d = start_beats;
               arvalid_d    = 1'b1;
               busy_d       = 1'b1;
               state_d      = StAddr;
            end
         end
         StAddr: begin
            if (axi.m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = StData;
            end
         end
         StData: begin
            if (r_hs) begin
               data_d       = axi.m_axi_rdata;
               valid_d      = 1'b1;
               remaining_d  = next_rem;
               burst_left_d = burst_left_q - 9'd1;
               if (axi.m_axi_rresp != 2'b00) error_d = 1'b1;
               // The local beat count is authoritative; a misplaced rlast only flags an error.
               if (axi.m_axi_rlast != (burst_left_q == 9'd1)) error_d = 1'b1;
               if (burst_left_q == 9'd1) begin
                  if (next_rem != 9'd0) begin
                     araddr_d     = next_addr;
                     arlen_d      = 8'(next_beats - 9'd1);
                     burst_left_d = next_beats;
                     arvalid_d    = 1'b1;
                     state_d      = StAddr;
                  end else begin
                     busy_d  = 1'b0;
                     state_d = StIdle;
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_reset) begin
         state_q      <= StIdle;
         araddr_q     <= '0;
         arlen_q      <= '0;
         arvalid_q    <= 1'b0;
         remaining_q  <= '0;
         burst_left_q <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         busy_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         arvalid_q    <= arvalid_d;
         remaining_q  <= remaining_d;
         burst_left_q <= burst_left_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         busy_q       <= busy_d;
         error_q      <= error_d;
      end
   end

   assign axi.m_axi_araddr  = araddr_q;
   assign axi.m_axi_arlen   = arlen_q;
   assign axi.m_axi_arsize  = 3'($clog2(DRAM_DATA_WIDTH / 8));
   assign axi.m_axi_arburst = 2'b01;
   assign axi.m_axi_arvalid = arvalid_q;
   assign axi.m_axi_rready  = rready;

   assign dram_read_data       = data_q;
   assign dram_read_data_valid = valid_q;
   assign dram_read_busy       = busy_q;
   assign read_error           = error_q;

endmodule

// File: tb/tb_dram_read_master.sv
// Directed bench: an AXI slave model returns address-derived data; a request-level model predicts
// the AR bursts and beat stream, and one compare process checks the DUT every cycle.
module tb_dram_read_master;
   localparam int unsigned AW = 39;
   localparam int unsigned DW = 128;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } ar_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_len;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid, busy, full, rerr;

   int n_vec  = 0;
   int n_fail = 0;

   ar_t        exp_ar[$];
   logic [127:0] exp_beats[$];
   logic       err_exp = 1'b0;

   int   inj_err_at   = -1;
   int   inj_rlast_at = -1;
   logic s_rlast_bad  = 1'b0;

   always #5 clk = ~clk;

   dram_read_master_if #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) axi ();

   dram_read_master #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) dut (
      .m_axi_aclk          (clk),
      .m_axi_reset         (rst),
      .dram_read_addr      (rd_addr),
      .dram_read_len       (rd_len),
      .dram_read_en        (rd_en),
      .dram_read_data      (rd_data),
      .dram_read_data_valid(rd_valid),
      .dram_read_busy      (busy),
      .dram_buffer_full    (full),
      .read_error          (rerr),
      .axi                 (axi)
   );

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [127:0] beat_data(input logic [AW-1:0] a);
      logic [31:0] w;
      w = a[31:0];
      return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'hDEAD_0000};
   endfunction

   // Request model: split at 4 KB byte boundaries, one expected beat per 16-byte line.
   function automatic void model_push(input logic [AW-1:0] a, input logic [7:0] l);
      longint unsigned cur;
      int total, room, n;
      cur   = longint'(a) & ~64'hF;
      total = int'(l) + 1;
      while (total > 0) begin
         room = (4096 - int'(cur % 4096)) / 16;
         n    = (total < room) ? total : room;
         exp_ar.push_back('{addr: AW'(cur), len: 8'(n - 1)});
         for (int i = 0; i < n; i++) exp_beats.push_back(beat_data(AW'(cur + 64'(16 * i))));
         cur   = cur + 64'(16 * n);
         total = total - n;
      end
   endfunction

   // AXI slave: serves bursts in order, rvalid held high whenever a burst is active.
   initial begin : slave
      ar_t  sq[$];
      ar_t  s_cur, s_ar;
      logic s_active, s_rst, s_arhs, s_rhs, s_new, nat_last;
      int   s_beat, req_beat;
      s_active = 1'b0; s_beat = 0; req_beat = 0; s_cur = '0;
      axi.m_axi_rvalid = 1'b0; axi.m_axi_rdata = '0; axi.m_axi_rresp = 2'b00;
      axi.m_axi_rlast  = 1'b0;
      forever begin
         @(negedge clk);
         s_rst  = rst;
         s_arhs = axi.m_axi_arvalid && axi.m_axi_arready;
         s_ar   = '{addr: axi.m_axi_araddr, len: axi.m_axi_arlen};
         s_rhs  = axi.m_axi_rvalid && axi.m_axi_rready;
         s_new  = rd_en && !busy;
         @(posedge clk);
         #1;
         if (s_rst) begin
            sq.delete();
            s_active = 1'b0; s_beat = 0; req_beat = 0;
         end else begin
            if (s_new) req_beat = 0;
            if (s_rhs) begin
               req_beat++;
               s_beat++;
               if (s_beat > int'(s_cur.len)) s_active = 1'b0;
            end
            if (s_arhs) sq.push_back(s_ar);
            if (!s_active && sq.size() > 0) begin
               s_cur = sq.pop_front(); s_active = 1'b1; s_beat = 0;
            end
         end
         nat_last         = (s_beat == int'(s_cur.len));
         axi.m_axi_rvalid = s_active;
         axi.m_axi_rdata  = beat_data(s_cur.addr + AW'(16 * s_beat));
         axi.m_axi_rlast  = (inj_rlast_at >= 0) ? (req_beat == inj_rlast_at) : nat_last;
         axi.m_axi_rresp  = (req_beat == inj_err_at) ? 2'b10 : 2'b00;
         s_rlast_bad      = axi.m_axi_rlast != nat_last;
      end
   end

   // Compare process: checks the effects of the previous edge, then samples for the next one.
   initial begin : compare
      logic         p_rst = 1'b1, p_hs = 1'b0, p_bad = 1'b0, p_arwait = 1'b0;
      logic [127:0] p_data = '0;
      logic [1:0]   p_resp = 2'b00;
      ar_t          p_ar = '0, e;
      forever begin
         @(negedge clk);
         if (p_rst) begin
            chk("rst_valid", 128'(rd_valid), 128'(0));
            chk("rst_busy", 128'(busy), 128'(0));
            chk("rst_error", 128'(rerr), 128'(0));
            chk("rst_arvalid", 128'(axi.m_axi_arvalid), 128'(0));
            chk("rst_rready", 128'(axi.m_axi_rready), 128'(0));
            chk("rst_araddr", 128'(axi.m_axi_araddr), 128'(0));
            chk("rst_arlen", 128'(axi.m_axi_arlen), 128'(0));
            chk("rst_data", 128'(rd_data), 128'(0));
            exp_ar.delete();
            exp_beats.delete();
            err_exp = 1'b0;
         end else begin
            chk("valid", 128'(rd_valid), 128'(p_hs));
            if (p_hs) begin
               chk("data_vs_bus", 128'(rd_data), p_data);
               if (exp_beats.size() == 0) chk("unexpected_beat", 128'(1), 128'(0));
               else chk("data_order", 128'(rd_data), exp_beats.pop_front());
               if (p_resp != 2'b00 || p_bad) err_exp = 1'b1;
            end
            chk("read_error", 128'(rerr), 128'(err_exp));
            chk("busy", 128'(busy), 128'(exp_beats.size() != 0));
            chk("ar_r_exclusive", 128'(axi.m_axi_arvalid && axi.m_axi_rready), 128'(0));
            if (full) chk("rready_when_full", 128'(axi.m_axi_rready), 128'(0));
            if (p_arwait) begin
               chk("ar_hold_valid", 128'(axi.m_axi_arvalid), 128'(1));
               chk("ar_hold_addr", 128'(axi.m_axi_araddr), 128'(p_ar.addr));
               chk("ar_hold_len", 128'(axi.m_axi_arlen), 128'(p_ar.len));
            end
            if (axi.m_axi_arvalid && axi.m_axi_arready) begin
               if (exp_ar.size() == 0) chk("unexpected_ar", 128'(1), 128'(0));
               else begin
                  e = exp_ar.pop_front();
                  chk("araddr", 128'(axi.m_axi_araddr), 128'(e.addr));
                  chk("arlen", 128'(axi.m_axi_arlen), 128'(e.len));
                  chk("arsize", 128'(axi.m_axi_arsize), 128'(3'b100));
                  chk("arburst", 128'(axi.m_axi_arburst), 128'(2'b01));
               end
            end
         end
         p_rst    = rst;
         p_hs     = axi.m_axi_rvalid && axi.m_axi_rready;
         p_data   = 128'(axi.m_axi_rdata);
         p_resp   = axi.m_axi_rresp;
         p_bad    = s_rlast_bad;
         p_arwait = axi.m_axi_arvalid && !axi.m_axi_arready;
         p_ar     = '{addr: axi.m_axi_araddr, len: axi.m_axi_arlen};
      end
   end

   task automatic issue(input logic [AW-1:0] a, input logic [7:0] l);
      @(posedge clk); #1;
      rd_addr = a; rd_len = l; rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
      model_push(a, l);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk); #1;
         if (!busy && exp_beats.size() == 0) done = 1'b1;
      end
      n_vec++;
      if (!done) begin
         n_fail++;
         $display("FAIL wait_idle: busy=%0b beats_left=%0d required idle", busy, exp_beats.size());
         exp_ar.delete();
         exp_beats.delete();
      end
      chk("ars_outstanding", 128'(exp_ar.size()), 128'(0));
   endtask

   initial begin : main
      rst = 1'b1; rd_addr = '0; rd_len = '0; rd_en = 1'b0; full = 1'b0;
      axi.m_axi_arready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      issue(39'h1000, 8'd15);
      chk("model_t1_ar", 128'(exp_ar[0]), 128'(ar_t'{addr: 39'h1000, len: 8'd15}));
      chk("model_t1_beats", 128'(exp_beats.size()), 128'(16));
      wait_idle();

      issue(39'h1F80, 8'd15);
      chk("model_t2_nar", 128'(exp_ar.size()), 128'(2));
      chk("model_t2_ar0", 128'(exp_ar[0]), 128'(ar_t'{addr: 39'h1F80, len: 8'd7}));
      chk("model_t2_ar1", 128'(exp_ar[1]), 128'(ar_t'{addr: 39'h2000, len: 8'd7}));
      wait_idle();

      issue(39'h1FF5, 8'd3);
      chk("model_t3_ar0", 128'(exp_ar[0]), 128'(ar_t'{addr: 39'h1FF0, len: 8'd0}));
      chk("model_t3_ar1", 128'(exp_ar[1]), 128'(ar_t'{addr: 39'h2000, len: 8'd2}));
      chk("model_t3_beat0", exp_beats[0], 128'h00001FF0_FFFFE00F_5A5A45AA_DEAD1FF0);
      wait_idle();

      issue(39'h3000, 8'd15);
      repeat (4) @(posedge clk);
      #1 full = 1'b1;
      repeat (5) @(posedge clk);
      #1 full = 1'b0;
      wait_idle();

      axi.m_axi_arready = 1'b0;
      issue(39'h5040, 8'd7);
      repeat (3) @(posedge clk);
      #1 axi.m_axi_arready = 1'b1;
      wait_idle();

      issue(39'h6000, 8'd15);
      repeat (3) @(posedge clk);
      #1 rd_addr = 39'h9000; rd_len = 8'd0; rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      wait_idle();

      issue(39'hF00, 8'd255);
      chk("model_t7_ar0", 128'(exp_ar[0]), 128'(ar_t'{addr: 39'hF00, len: 8'd15}));
      chk("model_t7_ar1", 128'(exp_ar[1]), 128'(ar_t'{addr: 39'h1000, len: 8'd239}));
      wait_idle();

      issue(39'h0, 8'd255);
      chk("model_t8_ar", 128'(exp_ar[0]), 128'(ar_t'{addr: 39'h0, len: 8'd255}));
      wait_idle();

      inj_err_at = 3;
      issue(39'h7000, 8'd7);
      wait_idle();
      inj_err_at = -1;
      issue(39'h7100, 8'd3);
      wait_idle();
      chk("error_sticky", 128'(rerr), 128'(1));

      issue(39'h8000, 8'd15);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_rready", 128'(axi.m_axi_rready), 128'(0));
      issue(39'h8800, 8'd3);
      wait_idle();
      chk("error_cleared", 128'(rerr), 128'(0));

      inj_rlast_at = 1;
      issue(39'hA000, 8'd3);
      wait_idle();
      inj_rlast_at = -1;
      chk("rlast_error", 128'(rerr), 128'(1));

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
